mdu_iter: RTL and testbench
===========================

Name: mdu_iter

Overview:
- Iterative RV64M multiply/divide unit; parametrised successor to the single-cycle combinational ALU mul/div/rem paths.
- Sits beside the ALU in EXU.
- Takes operands plus a 4-bit op code over a valid/ready handshake, iterates one bit per cycle, and returns the XLEN result with its own valid/ready.
- Supports flush and RISC-V divide-by-zero/overflow semantics.

Parameters:
- XLEN, 64, operand/result width; legal values 32 or 64.
- W_LEN, 32, width of the *W op variants; effective only when XLEN=64.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  synchronous reset, active low.
- in_valid  in  1  request valid.
- in_ready  out  1  unit can accept a request.
- in_op  in  4  operation select (see Behaviour).
- in_a  in  XLEN  operand A (rs1).
- in_b  in  XLEN  operand B (rs2).
- flush  in  1  abort the in-flight operation.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_res  out  XLEN  result.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous and active-low.
- Reset (rst_n=0 at posedge):
  - state=IDLE; out_valid=0; out_res=0; busy=0; in_ready=1 after release.
  - Reset mid-operation discards the operation.
- in_op codes:
  - 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU
  - 4 DIV, 5 DIVU, 6 REM, 7 REMU
  - 8 MULW, 9 DIVW, 10 DIVUW, 11 REMW, 12 REMUW
  - 13-15 illegal: result 0, latency 1.
  - With XLEN=32, codes 8-12 are also illegal.
- Handshake:
  - Accept when in_valid && in_ready.
  - in_ready = (state==IDLE) && !flush.
  - Operands and op are latched at accept; later input changes are ignored.
  - out_valid stays high, and out_res stays stable, until out_ready is sampled high. The unit then returns to IDLE.
  - A new request may be accepted only in IDLE, i.e. the cycle after the out handshake (no overlap).
- FSM states: IDLE, MUL, DIV, DONE.
  - IDLE -> MUL (mul ops), DIV (div/rem ops), or DONE (illegal op or div special case) on accept.
  - MUL/DIV -> DONE when the iteration counter reaches K-1.
  - DONE -> IDLE on out_ready.
  - flush in MUL/DIV/DONE -> IDLE next cycle; out_valid=0; no result is produced.
- Iteration count K: XLEN for full-width ops; W_LEN for W ops.
- Latency: accept at cycle 0; out_valid rises at cycle K+1. Special cases have out_valid at cycle 1.
- Multiply:
  - Radix-2 shift-add on magnitudes into a 2*XLEN product.
  - Sign correction per op signedness: MULH both signed; MULHSU A signed, B unsigned.
  - MUL returns the low XLEN bits; MULH* return the high XLEN bits.
  - MULW uses the low 32 bits of the operands; the 32-bit result is sign-extended to XLEN.
- Divide:
  - Restoring divide on magnitudes.
  - Quotient sign = sA^sB; remainder sign = sA.
  - W ops use in_a[31:0] and in_b[31:0] (signed or unsigned per op); the 32-bit result is sign-extended, including DIVUW and REMUW.
- Special cases (resolved at accept, no iteration):
  - Divide by zero: DIV/DIVU/DIVW/DIVUW return all-ones; REM* return the dividend (the W variants return the sign-extended low 32 bits).
  - Signed overflow (A = most-negative, B = -1, at the op width): DIV returns A; REM returns 0.
  - The zero and overflow test uses only the operative width: for W ops, B[31:0]==0.
- Simultaneous events:
  - flush beats out_ready in DONE.
  - flush in IDLE with in_valid: not accepted.
  - rst_n beats everything.

Optional Feature:
- Macro: MDU_FAST_MUL_EN.
- Defined: mul ops use a single-cycle combinational XLEN x XLEN multiplier. Flow is IDLE -> DONE with out_valid at cycle 1; the MUL state is unused.
- Undefined: iterative shift-add multiply with K-cycle latency as above.
- Division is iterative in both builds. Results are bit-identical in both builds.

Test Plan:
- DIV a=-7 (0xFFFF_FFFF_FFFF_FFF9), b=2 -> out_res=0xFFFF_FFFF_FFFF_FFFD (-3). out_valid at cycle 65 (XLEN=64). REM of the same operands -> 0xFFFF_FFFF_FFFF_FFFF (-1).
- DIVU a=5, b=0 -> all-ones at cycle 1. REMU a=5, b=0 -> 5. DIV a=0x8000_0000_0000_0000, b=-1 -> 0x8000_0000_0000_0000. REM of the same operands -> 0.
- MULHU a=b=0xFFFF_FFFF_FFFF_FFFF -> 0xFFFF_FFFF_FFFF_FFFE. MULHSU a=-1, b=2 -> all-ones. Latency 65 iterative, 1 with MDU_FAST_MUL_EN.
- MULW a=0x0000_0000_7FFF_FFFF, b=2 -> 0xFFFF_FFFF_FFFF_FFFE at cycle 33. DIVUW a=0x1_8000_0000, b=1 -> 0xFFFF_FFFF_8000_0000.
- Backpressure: hold out_ready=0 for 10 cycles after done -> out_res stable and in_ready=0 throughout. On out_ready=1, the unit returns to IDLE and accepts the next request the following cycle.
- flush at cycle 20 of a DIV -> out_valid never rises and in_ready=1 at cycle 21. rst_n=0 mid-MUL -> out_valid=0 and out_res=0 after the reset edge.

Source files
------------

// File: rtl/mdu_iter.sv
// mdu_iter: iterative RV64M multiply/divide unit, one result bit per cycle.
// Build macro MDU_FAST_MUL_EN: multiplies use a single-cycle combinational
// multiplier (IDLE -> DONE). Division stays iterative in both builds.

module mdu_iter #(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned W_LEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      in_op,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_res,
    output logic            busy
);

    localparam int unsigned CW = $clog2(XLEN);
    localparam int unsigned PW = 2 * XLEN;
    localparam logic [W_LEN-1:0] W_MIN = {1'b1, {(W_LEN-1){1'b0}}};
    localparam logic [XLEN-1:0]  X_MIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t state, state_nx;

    function automatic logic [XLEN-1:0] sext_w(input logic [W_LEN-1:0] v);
        return XLEN'($signed(v));
    endfunction

    // Sign-correct a magnitude product and pick the requested half.
    function automatic logic [XLEN-1:0] mul_fin(input logic [PW-1:0] prod,
                                                input logic neg, input logic hi,
                                                input logic w);
        logic [PW-1:0]   p;
        logic [XLEN-1:0] r;
        p = neg ? -prod : prod;
        r = hi ? p[PW-1:XLEN] : p[XLEN-1:0];
        return w ? sext_w(r[W_LEN-1:0]) : r;
    endfunction

    // Sign-correct quotient or remainder magnitude.
    function automatic logic [XLEN-1:0] div_fin(input logic [XLEN-1:0] quo,
                                                input logic [XLEN-1:0] rem,
                                                input logic neg, input logic sel_rem,
                                                input logic w);
        logic [XLEN-1:0] v;
        v = sel_rem ? rem : quo;
        v = neg ? -v : v;
        return w ? sext_w(v[W_LEN-1:0]) : v;
    endfunction

    // Request decode and operand magnitudes
    logic            d_mul, d_div, d_w, d_sa, d_sb, d_hi, d_rem;
    logic            neg_a, neg_b, d_neg, d_zero, d_ovf, d_imm;
    logic [XLEN-1:0] a_ext, b_ext, ma, mb, a_res, imm_res;

    // Datapath state
    logic [PW-1:0]   acc, mcand;
    logic [XLEN-1:0] mplier, rem_r, q_r, dvsr;
    logic [CW-1:0]   cnt;
    logic            r_w, r_hi, r_rem, r_neg;

    // Iteration step signals
    logic [PW-1:0]   acc_nx;
    logic [XLEN:0]   r_sh, diff;
    logic            ge, last, accept;
    logic [XLEN-1:0] rem_nx, q_nx, mul_res, div_res;

    assign in_ready = (state == S_IDLE) && !flush;
    assign accept   = in_valid && in_ready;

    // Decode op code, extend operands to the op width and take magnitudes.
    always_comb begin
        d_mul = 1'b0; d_div = 1'b0; d_w = 1'b0; d_sa = 1'b0;
        d_sb  = 1'b0; d_hi  = 1'b0; d_rem = 1'b0;
        case (in_op)
            4'd0:  d_mul = 1'b1;
            4'd1:  begin d_mul = 1'b1; d_hi = 1'b1; d_sa = 1'b1; d_sb = 1'b1; end
            4'd2:  begin d_mul = 1'b1; d_hi = 1'b1; d_sa = 1'b1; end
            4'd3:  begin d_mul = 1'b1; d_hi = 1'b1; end
            4'd4:  begin d_div = 1'b1; d_sa = 1'b1; d_sb = 1'b1; end
            4'd5:  d_div = 1'b1;
            4'd6:  begin d_div = 1'b1; d_rem = 1'b1; d_sa = 1'b1; d_sb = 1'b1; end
            4'd7:  begin d_div = 1'b1; d_rem = 1'b1; end
            4'd8:  begin d_mul = (XLEN == 64); d_w = (XLEN == 64); end
            4'd9:  begin d_div = (XLEN == 64); d_w = (XLEN == 64); d_sa = 1'b1; d_sb = 1'b1; end
            4'd10: begin d_div = (XLEN == 64); d_w = (XLEN == 64); end
            4'd11: begin d_div = (XLEN == 64); d_w = (XLEN == 64); d_rem = 1'b1;
                         d_sa = 1'b1; d_sb = 1'b1; end
            4'd12: begin d_div = (XLEN == 64); d_w = (XLEN == 64); d_rem = 1'b1; end
            default: ;
        endcase
        a_ext  = d_w ? (d_sa ? sext_w(in_a[W_LEN-1:0]) : XLEN'(in_a[W_LEN-1:0])) : in_a;
        b_ext  = d_w ? (d_sb ? sext_w(in_b[W_LEN-1:0]) : XLEN'(in_b[W_LEN-1:0])) : in_b;
        neg_a  = d_sa && a_ext[XLEN-1];
        neg_b  = d_sb && b_ext[XLEN-1];
        ma     = neg_a ? -a_ext : a_ext;
        mb     = neg_b ? -b_ext : b_ext;
        d_neg  = neg_a ^ (neg_b && !d_rem);
        d_zero = d_div && (mb == '0);
        d_ovf  = d_div && d_sa && (b_ext == '1) &&
                 (a_ext == (d_w ? sext_w(W_MIN) : X_MIN));
        a_res  = d_w ? sext_w(in_a[W_LEN-1:0]) : in_a;
    end

`ifdef MDU_FAST_MUL_EN
    logic [PW-1:0] fast_prod;
    assign fast_prod = PW'(ma) * PW'(mb);
`endif

    // Result for requests that complete without iterating.
    always_comb begin
        imm_res = '0;
        if (d_zero) begin
            imm_res = d_rem ? a_res : '1;
        end else if (d_ovf) begin
            imm_res = d_rem ? '0 : a_res;
`ifdef MDU_FAST_MUL_EN
        end else if (d_mul) begin
            imm_res = mul_fin(fast_prod, d_neg, d_hi, d_w);
`endif
        end
`ifdef MDU_FAST_MUL_EN
        d_imm = !d_div || d_zero || d_ovf;
`else
        d_imm = !(d_mul || d_div) || d_zero || d_ovf;
`endif
    end

    // One shift-add step and one restoring-divide step, plus final results.
    always_comb begin
        acc_nx  = acc + (mplier[0] ? mcand : '0);
        r_sh    = {rem_r, q_r[XLEN-1]};
        diff    = r_sh - {1'b0, dvsr};
        ge      = !diff[XLEN];
        rem_nx  = ge ? diff[XLEN-1:0] : r_sh[XLEN-1:0];
        q_nx    = {q_r[XLEN-2:0], ge};
        last    = (cnt == (r_w ? CW'(W_LEN - 1) : CW'(XLEN - 1)));
        mul_res = mul_fin(acc_nx, r_neg, r_hi, r_w);
        div_res = div_fin(q_nx, rem_nx, r_neg, r_rem, r_w);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (accept) state_nx = d_imm ? S_DONE : (d_mul ? S_MUL : S_DIV);
            S_MUL, S_DIV: begin
                if (flush)     state_nx = S_IDLE;
                else if (last) state_nx = S_DONE;
            end
            S_DONE: if (flush || out_ready) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Operand latch, iteration registers and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0; out_res <= '0; busy <= 1'b0;
            acc <= '0; mcand <= '0; mplier <= '0;
            rem_r <= '0; q_r <= '0; dvsr <= '0; cnt <= '0;
            r_w <= 1'b0; r_hi <= 1'b0; r_rem <= 1'b0; r_neg <= 1'b0;
        end else begin
            busy      <= (state_nx != S_IDLE);
            out_valid <= (state_nx == S_DONE);
            case (state)
                S_IDLE: if (accept) begin
                    r_w <= d_w; r_hi <= d_hi; r_rem <= d_rem; r_neg <= d_neg;
                    cnt    <= '0;
                    acc    <= '0;
                    mcand  <= PW'(ma);
                    mplier <= mb;
                    rem_r  <= '0;
                    q_r    <= d_w ? (ma << (XLEN - W_LEN)) : ma;
                    dvsr   <= mb;
                    if (d_imm) out_res <= imm_res;
                end
                S_MUL: begin
                    acc    <= acc_nx;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CW'(1);
                    if (last && !flush) out_res <= mul_res;
                end
                S_DIV: begin
                    rem_r <= rem_nx;
                    q_r   <= q_nx;
                    cnt   <= cnt + CW'(1);
                    if (last && !flush) out_res <= div_res;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: directed-vector bench for mdu_iter (XLEN=64, W_LEN=32) with a
// reference model built from plain SV arithmetic.
`timescale 1ns/1ps

module tb_mdu_iter;

    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_ready, flush, out_valid, out_ready, busy;
    logic [3:0]  in_op;
    logic [63:0] in_a, in_b, out_res;

    int          n_vec = 0;
    int          n_err = 0;
    int          cur = -1;
    logic        exp_active = 1'b0;
    logic [63:0] exp_res = '0;

    typedef struct {
        logic [3:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        int          hold;
        bit          use_lit;
        logic [63:0] lit;
    } vec_t;

    vec_t vecs[$];

    mdu_iter #(.XLEN(64), .W_LEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_a(in_a), .in_b(in_b), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #400_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "time limit");
    end

    function automatic logic [63:0] sx32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    // Reference results straight from the RISC-V M definitions.
    function automatic logic [63:0] model(input logic [3:0] op, input logic [63:0] a,
                                          input logic [63:0] b);
        logic [127:0] p;
        logic [63:0]  r;
        logic [31:0]  a32, b32, r32;
        logic         ovf64, ovf32;
        a32   = a[31:0];
        b32   = b[31:0];
        ovf64 = (a == 64'h8000_0000_0000_0000) && (b == 64'hFFFF_FFFF_FFFF_FFFF);
        ovf32 = (a32 == 32'h8000_0000) && (b32 == 32'hFFFF_FFFF);
        case (op)
            4'd0: begin p = {64'd0, a} * {64'd0, b}; return p[63:0]; end
            4'd1: begin p = {{64{a[63]}}, a} * {{64{b[63]}}, b}; return p[127:64]; end
            4'd2: begin p = {{64{a[63]}}, a} * {64'd0, b}; return p[127:64]; end
            4'd3: begin p = {64'd0, a} * {64'd0, b}; return p[127:64]; end
            4'd4: begin
                if (b == 0) return 64'hFFFF_FFFF_FFFF_FFFF;
                if (ovf64) return a;
                r = $signed(a) / $signed(b); return r;
            end
            4'd5: begin
                if (b == 0) return 64'hFFFF_FFFF_FFFF_FFFF;
                r = a / b; return r;
            end
            4'd6: begin
                if (b == 0) return a;
                if (ovf64) return 64'd0;
                r = $signed(a) % $signed(b); return r;
            end
            4'd7: begin
                if (b == 0) return a;
                r = a % b; return r;
            end
            4'd8: begin r32 = a32 * b32; return sx32(r32); end
            4'd9: begin
                if (b32 == 0) return 64'hFFFF_FFFF_FFFF_FFFF;
                if (ovf32) return sx32(a32);
                r32 = $signed(a32) / $signed(b32); return sx32(r32);
            end
            4'd10: begin
                if (b32 == 0) return 64'hFFFF_FFFF_FFFF_FFFF;
                r32 = a32 / b32; return sx32(r32);
            end
            4'd11: begin
                if (b32 == 0) return sx32(a32);
                if (ovf32) return 64'd0;
                r32 = $signed(a32) % $signed(b32); return sx32(r32);
            end
            4'd12: begin
                if (b32 == 0) return sx32(a32);
                r32 = a32 % b32; return sx32(r32);
            end
            default: return 64'd0;
        endcase
    endfunction

    // Clock edges from the accept edge until out_valid is visible.
    function automatic int exp_lat(input logic [3:0] op, input logic [63:0] a,
                                   input logic [63:0] b);
        bit w, dv, sg;
        w  = (op >= 4'd8) && (op <= 4'd12);
        dv = ((op >= 4'd4) && (op <= 4'd7)) || ((op >= 4'd9) && (op <= 4'd12));
        sg = (op == 4'd4) || (op == 4'd6) || (op == 4'd9) || (op == 4'd11);
        if (op >= 4'd13) return 0;
        if (dv) begin
            if (w ? (b[31:0] == 0) : (b == 0)) return 0;
            if (sg && (w ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                         : (a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF)))
                return 0;
        end else begin
`ifdef MDU_FAST_MUL_EN
            return 0;
`endif
        end
        return w ? 32 : 64;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        n_vec++;
        if (act !== want) begin
            n_err++;
            $display("FAIL vec%0d %s: got %h expected %h", cur, name, act, want);
        end
    endtask

    // Result, stability and handshake check on every cycle out_valid is high.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (!exp_active) chk("unexpected_out_valid", 64'(out_valid), 64'd0);
            else             chk("out_res", out_res, exp_res);
            chk("in_ready_while_valid", 64'(in_ready), 64'd0);
        end
    end

    // Issue one request, scramble inputs after accept, measure latency, then handshake.
    task automatic run_op(input vec_t v);
        int edges;
        cur++;
        @(negedge clk);
        out_ready  = 1'b0;
        in_op      = v.op;
        in_a       = v.a;
        in_b       = v.b;
        in_valid   = 1'b1;
        exp_res    = model(v.op, v.a, v.b);
        exp_active = 1'b1;
        #1 chk("in_ready_idle", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_op    = 4'($urandom);
        in_a     = {$urandom, $urandom};
        in_b     = {$urandom, $urandom};
        edges    = 0;
        while (!out_valid && edges < 200) begin
            @(posedge clk); #1;
            edges++;
        end
        chk("latency", 64'(edges), 64'(exp_lat(v.op, v.a, v.b)));
        if (v.use_lit) chk("literal", out_res, v.lit);
        repeat (v.hold) begin @(posedge clk); #1; end
        chk("valid_held", 64'(out_valid), 64'd1);
        chk("busy_done", 64'(busy), 64'd1);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        exp_active = 1'b0;
        out_ready  = 1'b0;
        chk("valid_after_hs", 64'(out_valid), 64'd0);
        chk("in_ready_after_hs", 64'(in_ready), 64'd1);
        chk("busy_after_hs", 64'(busy), 64'd0);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        in_op = '0; in_a = '0; in_b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_res", out_res, 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        vecs.push_back('{4'd4,  64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD});
        vecs.push_back('{4'd6,  64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF});
        vecs.push_back('{4'd5,  64'd5, 64'd0, 0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF});
        vecs.push_back('{4'd7,  64'd5, 64'd0, 0, 1'b1, 64'd5});
        vecs.push_back('{4'd4,  64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1'b1, 64'h8000_0000_0000_0000});
        vecs.push_back('{4'd6,  64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1'b1, 64'd0});
        vecs.push_back('{4'd3,  64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 10, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE});
        vecs.push_back('{4'd2,  64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF});
        vecs.push_back('{4'd8,  64'h0000_0000_7FFF_FFFF, 64'd2, 0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE});
        vecs.push_back('{4'd10, 64'h0000_0001_8000_0000, 64'd1, 0, 1'b1, 64'hFFFF_FFFF_8000_0000});
        vecs.push_back('{4'd1,  64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF});
        vecs.push_back('{4'd1,  64'h4000_0000_0000_0000, 64'd4, 0, 1'b1, 64'd1});
        vecs.push_back('{4'd5,  64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 0, 1'b1, 64'h5555_5555_5555_5555});
        vecs.push_back('{4'd9,  64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF2});
        vecs.push_back('{4'd11, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE});
        vecs.push_back('{4'd12, 64'h0000_0000_FFFF_FFFF, 64'h10, 0, 1'b1, 64'h0F});
        vecs.push_back('{4'd10, 64'h1234, 64'h0000_ABCD_0000_0000, 0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF});
        vecs.push_back('{4'd9,  64'h8000_0000, 64'hFFFF_FFFF, 0, 1'b1, 64'hFFFF_FFFF_8000_0000});
        vecs.push_back('{4'd11, 64'h1234_5678_8765_4321, 64'h5_0000_0000, 0, 1'b1, 64'hFFFF_FFFF_8765_4321});
        vecs.push_back('{4'd14, 64'd5, 64'd7, 0, 1'b1, 64'd0});
        vecs.push_back('{4'd7,  64'd100, 64'd7, 2, 1'b1, 64'd2});
        vecs.push_back('{4'd6,  64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 0, 1'b1, 64'd1});
        vecs.push_back('{4'd4,  64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD});
        vecs.push_back('{4'd0,  64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 0, 1'b0, 64'd0});
        vecs.push_back('{4'd2,  64'h7654_3210_FEDC_BA98, 64'hF000_0000_0000_0001, 0, 1'b0, 64'd0});
        vecs.push_back('{4'd0,  64'd3, 64'd5, 0, 1'b1, 64'd15});

        foreach (vecs[i]) run_op(vecs[i]);

        // Flush a DIV during cycle 20: no result, back to IDLE at cycle 21.
        cur++;
        @(negedge clk);
        in_op = 4'd4; in_a = 64'd1000; in_b = 64'd3; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("flush_busy", 64'(busy), 64'd1);
        repeat (19) @(posedge clk);
        @(negedge clk); flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        #1;
        chk("flush_in_ready", 64'(in_ready), 64'd1);
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        chk("flush_busy_after", 64'(busy), 64'd0);

        // flush in IDLE blocks acceptance.
        @(negedge clk);
        flush = 1'b1; in_valid = 1'b1; in_op = 4'd5; in_a = 64'd9; in_b = 64'd3;
        #1 chk("flush_idle_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_idle_busy", 64'(busy), 64'd0);
        repeat (80) @(posedge clk);
        #1;

        // Reset in the middle of a multiply.
        cur++;
        @(negedge clk);
        in_op = 4'd3; in_a = 64'hFFFF_FFFF_FFFF_FFFF; in_b = 64'd7; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk); rst_n = 1'b0;
        @(posedge clk); #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_out_res", out_res, 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        @(negedge clk); rst_n = 1'b1;
        #1 chk("midrst_in_ready", 64'(in_ready), 64'd1);
        repeat (80) @(posedge clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
